alu_seq: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU for the MIPS core. Executes the existing logic/arithmetic/shift set with one-cycle registered latency and adds iterative unsigned multiply and divide driven by a start/ready/valid handshake. It sits in the execute stage; the control unit stalls the pipeline while `ready` is low.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_iter.sv | 75 +++++++
 rtl/alu_seq.sv | 139 +++++++++++++
 tb/tb_alu_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcode values and FSM state encoding.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_LUI   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine for MULTU (shift-add) and DIVU (restoring), one bit per cycle.
// A single 2*WIDTH accumulator is shared by both: {hi, lo} ends as
// {product high, product low} or {remainder, quotient}.
// Divider path exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 run,
`ifdef ALU_SEQ_DIV_EN
    input  logic                 div,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_nxt;
`ifdef ALU_SEQ_DIV_EN
    logic               is_div;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_nxt;
`endif

    // One iteration step of the selected algorithm
    always_comb begin
        // multiplier sits in the low half; add multiplicand on bit 0, then shift right
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt = {sum, acc[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        // shift {rem, quo} left; keep the bit that leaves rem so the trial is exact
        diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
        div_nxt = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_nxt = is_div ? div_nxt : mul_nxt;
`else
        acc_nxt = mul_nxt;
`endif
    end

    assign last = run && (cnt == LAST_CNT);

    // Accumulator, held operand and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            opb <= '0;
            cnt <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div <= 1'b0;
`endif
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, a};
            opb <= b;
            cnt <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div <= div;
`endif
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with iterative MULTU/DIVU and start/ready/valid.
// Optional divider: define ALU_SEQ_DIV_EN; otherwise DIVU is a 1-cycle op giving 0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   ALUResult,
    output logic [WIDTH-1:0]   Hi,
    output logic               Zero,
    output logic               DivByZero
);

    state_t             state, state_nxt;
    logic               accept;
    logic               iter_op;
    logic               run;
    logic               last;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   op_res;
    logic [WIDTH-1:0]   op_hi;
    logic               op_dbz;

`ifdef ALU_SEQ_DIV_EN
    logic div_sel;
    assign div_sel = (ALUOperation == OP_DIVU);
    // divide by zero is resolved immediately and never enters RUN
    assign iter_op = (ALUOperation == OP_MULTU) || (div_sel && (B != '0));
`else
    assign iter_op = (ALUOperation == OP_MULTU);
`endif

    assign ready = (state == IDLE);
    assign run   = (state == RUN);

    alu_seq_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (accept && iter_op),
        .run     (run),
`ifdef ALU_SEQ_DIV_EN
        .div     (div_sel),
`endif
        .a       (A),
        .b       (B),
        .last    (last),
        .acc_nxt (acc_nxt)
    );

    // Single-cycle result, computed from the operands presented at accept
    always_comb begin
        op_res = '0;
        op_hi  = '0;
        op_dbz = 1'b0;
        case (ALUOperation)
            OP_AND: op_res = A & B;
            OP_OR:  op_res = A | B;
            OP_NOR: op_res = ~(A | B);
            OP_ADD: op_res = A + B;
            OP_SUB: op_res = A - B;
            OP_SLL: op_res = B << shamt;
            OP_SRL: op_res = B >> shamt;
            OP_LUI: op_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SRA: op_res = $signed(B) >>> shamt;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                op_res = '1;
                op_hi  = A;
                op_dbz = 1'b1;
            end
`endif
            default: op_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: single-cycle ops go straight to DONE, iterative ops spend WIDTH cycles in RUN
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = iter_op ? RUN : DONE;
                end
            end
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers; valid marks the single cycle in which they were updated
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResult <= '0;
            Hi        <= '0;
            Zero      <= 1'b1;
            DivByZero <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept && !iter_op) begin
                ALUResult <= op_res;
                Hi        <= op_hi;
                Zero      <= (op_res == '0);
                DivByZero <= op_dbz;
                valid     <= 1'b1;
            end else if (last) begin
                ALUResult <= acc_nxt[WIDTH-1:0];
                Hi        <= acc_nxt[2*WIDTH-1:WIDTH];
                Zero      <= (acc_nxt[WIDTH-1:0] == '0);
                DivByZero <= 1'b0;
                valid     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (default WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B;
    logic [4:0]  shamt;
    logic        ready, valid, Zero, DivByZero;
    logic [31:0] ALUResult, Hi;

    int vectors;
    int miscompares;

    alu_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (ALUOperation),
        .A            (A),
        .B            (B),
        .shamt        (shamt),
        .ready        (ready),
        .valid        (valid),
        .ALUResult    (ALUResult),
        .Hi           (Hi),
        .Zero         (Zero),
        .DivByZero    (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the operation definitions; lat = cycles from accept to valid
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic [31:0] h,
                         output logic d, output int lat);
        logic [63:0] p;
        r = 32'd0; h = 32'd0; d = 1'b0; lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = ~(a | b);
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: r = b << sh;
            4'd6: r = b >> sh;
            4'd7: r = {b[15:0], 16'h0000};
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = $signed(b) >>> sh;
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0]; h = p[63:32]; lat = 33;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd11: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF; h = a; d = 1'b1;
                end else begin
                    r = a / b; h = a % b; lat = 33;
                end
            end
`endif
            default: r = 32'd0;
        endcase
    endtask

    // Called at a negedge with ready expected high; returns at the negedge after valid.
    // hold keeps start high and scrambles the inputs while the op is in flight.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit hold);
        logic [31:0] er, eh;
        logic        ed;
        int          el, lat;
        bit          busy_ok;
        model(op, a, b, sh, er, eh, ed, el);
        chk("ready_before_accept", 64'(ready), 64'(1));
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!valid && lat < 100) begin
            if (ready) busy_ok = 1'b0;
            if (hold) begin
                ALUOperation = 4'($urandom_range(0, 15));
                A = $urandom; B = $urandom; shamt = 5'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(el));
        chk("ready_low_while_busy", 64'(busy_ok && !ready), 64'(1));
        chk("result", 64'(ALUResult), 64'(er));
        chk("hi", 64'(Hi), 64'(eh));
        chk("zero", 64'(Zero), 64'(er == 32'd0));
        chk("divbyzero", 64'(DivByZero), 64'(ed));
        @(negedge clk);
        chk("ready_returns", 64'(ready), 64'(1));
        chk("valid_one_cycle", 64'(valid), 64'(0));
        chk("result_holds", 64'(ALUResult), 64'(er));
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b0; ALUOperation = 4'd0; A = 32'd0; B = 32'd0; shamt = 5'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_result", 64'(ALUResult), 64'(0));
        chk("rst_hi", 64'(Hi), 64'(0));
        chk("rst_zero", 64'(Zero), 64'(1));
        chk("rst_dbz", 64'(DivByZero), 64'(0));

        // directed boundary cases
        do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk("add_wrap_literal", 64'(ALUResult), 64'(0));
        do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        chk("slt_literal", 64'(ALUResult), 64'(1));
        do_op(4'd9, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        chk("sra_literal", 64'(ALUResult), 64'(32'hF800_0000));
        do_op(4'd7, 32'd0, 32'h1234_ABCD, 5'd0, 1'b0);
        do_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
        chk("multu_hi_literal", 64'(Hi), 64'(32'hFFFF_FFFE));
        chk("multu_lo_literal", 64'(ALUResult), 64'(1));
        do_op(4'd11, 32'd100, 32'd7, 5'd0, 1'b0);
        do_op(4'd11, 32'd5, 32'd0, 5'd0, 1'b0);
        do_op(4'd3, 32'd1, 32'd1, 5'd0, 1'b0);
        do_op(4'd14, 32'h55, 32'hAA, 5'd3, 1'b0);

        // randomized ops, some with start held and inputs scrambled mid-flight
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 5 == 0) rop = 4'd10;
            if (i % 5 == 1) rop = 4'd11;
            ra = $urandom;
            rb = $urandom;
            if (rop == 4'd11 && $urandom_range(0, 3) == 0) rb = 32'd0;
            if (rop == 4'd11 && $urandom_range(0, 2) == 0) rb = rb >> 20;
            do_op(rop, ra, rb, 5'($urandom), bit'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(negedge clk);

        // reset during MULTU iteration ~10, then a fresh op
        start = 1'b1; ALUOperation = 4'd10; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", 64'(ready), 64'(1));
        chk("midrst_valid", 64'(valid), 64'(0));
        chk("midrst_result", 64'(ALUResult), 64'(0));
        chk("midrst_hi", 64'(Hi), 64'(0));
        chk("midrst_zero", 64'(Zero), 64'(1));
        do_op(4'd3, 32'd2, 32'd3, 5'd0, 1'b0);
        chk("post_rst_add", 64'(ALUResult), 64'(5));
        do_op(4'd10, 32'd7, 32'd6, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
